sprite_move_scheduler: RTL and testbench

//  Owns the on-screen centre (x,y) of the triangle sprite renderer. Two requesters
//  (A = locator result, B = manual/debug input) post target positions through a
//  req/ack handshake. A round-robin arbiter stores one pending target. At each frame

---
 rtl/sprite_move_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_sprite_move_scheduler.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_scheduler.sv
// sprite_move_scheduler
//
// Owns the on-screen centre (x,y) of the triangle sprite. Two requesters post
// target positions through a req/ack handshake, and a round-robin arbiter keeps
// one pending target. At every frame start the sprite takes one step of at most
// STEP px per axis toward its target. The sprite therefore only moves during
// vertical blank, so the renderer never shows a half-moved sprite.
//
// Ports
//   clock        in   system/pixel clock
//   reset        in   synchronous, active-high
//   frame_start  in   one-cycle pulse in the first cycle of vertical blank
//   req_a        in   requester A (locator) target valid, held until ack_a
//   tgt_a_x/y    in   signed 12-bit target from A
//   ack_a        out  one-cycle pulse: A's target was accepted
//   req_b        in   requester B (manual/debug) target valid, held until ack_b
//   tgt_b_x/y    in   signed 12-bit target from B
//   ack_b        out  one-cycle pulse: B's target was accepted
//   x, y         out  signed 12-bit sprite centre, registered
//   moving       out  high while the scheduler is in MOVE
//   arrived      out  one-cycle pulse when a move reaches its target

module sprite_move_scheduler #(
  parameter int STEP   = 4,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int X_MAX  = 1023,
  parameter int Y_MAX  = 767,
  parameter int HOME_X = 512,
  parameter int HOME_Y = 384
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               req_a,
  input  logic signed [11:0] tgt_a_x,
  input  logic signed [11:0] tgt_a_y,
  output logic               ack_a,
  input  logic               req_b,
  input  logic signed [11:0] tgt_b_x,
  input  logic signed [11:0] tgt_b_y,
  output logic               ack_b,
  output logic signed [11:0] x,
  output logic signed [11:0] y,
  output logic               moving,
  output logic               arrived
);

  // Clamp window keeps the whole sprite on screen.
  localparam logic signed [11:0] X_LO   = 12'(WIDTH / 2);
  localparam logic signed [11:0] X_HI   = 12'(X_MAX - WIDTH / 2);
  localparam logic signed [11:0] Y_LO   = 12'(HEIGHT / 2);
  localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - HEIGHT / 2);
  localparam logic signed [11:0] HOME_XS = 12'(HOME_X);
  localparam logic signed [11:0] HOME_YS = 12'(HOME_Y);

  typedef enum logic {
    IDLE,
    MOVE
  } moveState_t;

  moveState_t state_q, state_d;

  logic signed [11:0] posX_q, posX_d;
  logic signed [11:0] posY_q, posY_d;
  logic signed [11:0] tgtX_q, tgtX_d;
  logic signed [11:0] tgtY_q, tgtY_d;
  logic signed [11:0] pendX_q, pendX_d;
  logic signed [11:0] pendY_q, pendY_d;
  logic               pendValid_q, pendValid_d;
  logic               lastGrantB_q, lastGrantB_d;
  logic               ackA_q, ackA_d;
  logic               ackB_q, ackB_d;
  logic               arrived_q, arrived_d;

  // Working values for the frame-start step.
  logic               liveA, liveB, grantA, grantB;
  logic signed [11:0] stepTgtX, stepTgtY;
  logic signed [11:0] nextX, nextY;

  // Limits a requested coordinate to the visible window.
  function automatic logic signed [11:0] clampAxis(
    input logic signed [11:0] v,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] r;
    r = v;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

  // One axis step: move by the 13-bit signed difference, limited to +/-STEP,
  // so the sprite can land exactly on the target but never overshoot it.
  function automatic logic signed [11:0] stepAxis(
    input logic signed [11:0] pos,
    input logic signed [11:0] tgt
  );
    logic signed [12:0] diff;
    logic signed [12:0] lim;
    diff = {tgt[11], tgt} - {pos[11], pos};
    lim  = 13'(STEP);
    if (diff > lim) begin
      diff = lim;
    end else if (diff < -lim) begin
      diff = -lim;
    end
    return pos + diff[11:0];
  endfunction

  // A request that is still high while its own ack is high is treated as
  // the old request, so it cannot be taken twice.
  assign liveA  = req_a && !ackA_q;
  assign liveB  = req_b && !ackB_q;
  assign grantA = !pendValid_q && liveA && (!liveB || lastGrantB_q);
  assign grantB = !pendValid_q && liveB && !grantA;

  // At a frame start, a pending target (if any) becomes the new target
  // before the step, so the step already heads toward it.
  assign stepTgtX = pendValid_q ? pendX_q : tgtX_q;
  assign stepTgtY = pendValid_q ? pendY_q : tgtY_q;
  assign nextX    = stepAxis(posX_q, stepTgtX);
  assign nextY    = stepAxis(posY_q, stepTgtY);

  // Next-state logic: arbitration into the pending slot at any time, then
  // the target update, position step and state change at frame start.
  always_comb begin
    state_d      = state_q;
    posX_d       = posX_q;
    posY_d       = posY_q;
    tgtX_d       = tgtX_q;
    tgtY_d       = tgtY_q;
    pendX_d      = pendX_q;
    pendY_d      = pendY_q;
    pendValid_d  = pendValid_q;
    lastGrantB_d = lastGrantB_q;
    ackA_d       = 1'b0;
    ackB_d       = 1'b0;
    arrived_d    = 1'b0;

    // Grants only happen with the slot empty, so they never collide with
    // the frame-start drain below.
    if (grantA) begin
      pendX_d      = clampAxis(tgt_a_x, X_LO, X_HI);
      pendY_d      = clampAxis(tgt_a_y, Y_LO, Y_HI);
      pendValid_d  = 1'b1;
      lastGrantB_d = 1'b0;
      ackA_d       = 1'b1;
    end else if (grantB) begin
      pendX_d      = clampAxis(tgt_b_x, X_LO, X_HI);
      pendY_d      = clampAxis(tgt_b_y, Y_LO, Y_HI);
      pendValid_d  = 1'b1;
      lastGrantB_d = 1'b1;
      ackB_d       = 1'b1;
    end

    if (frame_start) begin
      if (pendValid_q) begin
        tgtX_d      = pendX_q;
        tgtY_d      = pendY_q;
        pendValid_d = 1'b0;
      end
      posX_d = nextX;
      posY_d = nextY;
      // Arrival is reported when a move completes: either the state was
      // already MOVE, or this single step actually moved the sprite onto
      // the target. A target equal to the current position from IDLE is
      // silent.
      if (nextX == stepTgtX && nextY == stepTgtY) begin
        if (state_q == MOVE || nextX != posX_q || nextY != posY_q) begin
          arrived_d = 1'b1;
        end
        state_d = IDLE;
      end else begin
        state_d = MOVE;
      end
    end
  end

  // State register with synchronous reset back to home, empty slot and B
  // recorded as last grant so that A wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      posX_q       <= HOME_XS;
      posY_q       <= HOME_YS;
      tgtX_q       <= HOME_XS;
      tgtY_q       <= HOME_YS;
      pendX_q      <= HOME_XS;
      pendY_q      <= HOME_YS;
      pendValid_q  <= 1'b0;
      lastGrantB_q <= 1'b1;
      ackA_q       <= 1'b0;
      ackB_q       <= 1'b0;
      arrived_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      posX_q       <= posX_d;
      posY_q       <= posY_d;
      tgtX_q       <= tgtX_d;
      tgtY_q       <= tgtY_d;
      pendX_q      <= pendX_d;
      pendY_q      <= pendY_d;
      pendValid_q  <= pendValid_d;
      lastGrantB_q <= lastGrantB_d;
      ackA_q       <= ackA_d;
      ackB_q       <= ackB_d;
      arrived_q    <= arrived_d;
    end
  end

  assign x       = posX_q;
  assign y       = posY_q;
  assign ack_a   = ackA_q;
  assign ack_b   = ackB_q;
  assign arrived = arrived_q;
  assign moving  = (state_q == MOVE);

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// tb_sprite_move_scheduler
//
// Directed scenarios for the sprite scheduler followed by a long randomized
// run compared cycle by cycle against a behavioural model of the movement
// rules (integer arithmetic on positions, targets and a one-entry slot).

module tb_sprite_move_scheduler;

  localparam int STEP   = 4;
  localparam int X_LO   = 32;
  localparam int X_HI   = 991;
  localparam int Y_LO   = 32;
  localparam int Y_HI   = 735;
  localparam int HOME_X = 512;
  localparam int HOME_Y = 384;

  logic               clock = 1'b0;
  logic               reset;
  logic               frameStart;
  logic               reqA, reqB;
  logic signed [11:0] tgtAX, tgtAY, tgtBX, tgtBY;
  logic               ackA, ackB, moving, arrived;
  logic signed [11:0] x, y;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state.
  int mX, mY, mTx, mTy, mPx, mPy;
  bit mPend, mLastB, mMoving, mAckA, mAckB, mArr;

  sprite_move_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .frame_start(frameStart),
    .req_a      (reqA),
    .tgt_a_x    (tgtAX),
    .tgt_a_y    (tgtAY),
    .ack_a      (ackA),
    .req_b      (reqB),
    .tgt_b_x    (tgtBX),
    .tgt_b_y    (tgtBY),
    .ack_b      (ackB),
    .x          (x),
    .y          (y),
    .moving     (moving),
    .arrived    (arrived)
  );

  always #5 clock = ~clock;

  function automatic int clampI(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int approach(int p, int t);
    if (t > p) return (t - p > STEP) ? p + STEP : t;
    if (t < p) return (p - t > STEP) ? p - STEP : t;
    return p;
  endfunction

  function automatic logic signed [11:0] pickTarget(int base);
    if ($urandom_range(1, 0) == 1) return 12'($urandom);
    return 12'(base + int'($urandom_range(20, 0)) - 10);
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic modelStep();
    bit aLive, bLive, pickA, hadPend;
    int oldPx, oldPy, ox, oy;
    if (reset) begin
      mX = HOME_X; mY = HOME_Y; mTx = HOME_X; mTy = HOME_Y;
      mPend = 0; mLastB = 1; mMoving = 0; mAckA = 0; mAckB = 0; mArr = 0;
      return;
    end
    aLive   = reqA && !mAckA;
    bLive   = reqB && !mAckB;
    hadPend = mPend;
    oldPx   = mPx;
    oldPy   = mPy;
    mArr    = 0;
    mAckA   = 0;
    mAckB   = 0;
    if (!hadPend && (aLive || bLive)) begin
      pickA = aLive && (!bLive || mLastB);
      mPend = 1;
      if (pickA) begin
        mPx = clampI(int'(tgtAX), X_LO, X_HI);
        mPy = clampI(int'(tgtAY), Y_LO, Y_HI);
      end else begin
        mPx = clampI(int'(tgtBX), X_LO, X_HI);
        mPy = clampI(int'(tgtBY), Y_LO, Y_HI);
      end
      mLastB = !pickA;
      mAckA  = pickA;
      mAckB  = !pickA;
    end
    if (frameStart) begin
      if (hadPend) begin
        mTx = oldPx; mTy = oldPy; mPend = 0;
      end
      ox = mX; oy = mY;
      mX = approach(mX, mTx);
      mY = approach(mY, mTy);
      if (mX == mTx && mY == mTy) begin
        if (mMoving || mX != ox || mY != oy) mArr = 1;
        mMoving = 0;
      end else begin
        mMoving = 1;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus_frame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic applyReset();
    reqA = 0; reqB = 0; frameStart = 0; reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    if (x !== 12'(HOME_X) || y !== 12'(HOME_Y)) begin
      failCount++;
      $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (%0d,%0d)", x, y, HOME_X, HOME_Y);
    end
    testCount++;
    if (moving !== 1'b0 || arrived !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got moving=%b arrived=%b expected 0 0", moving, arrived);
    end
    testCount++;
    if (ackA !== 1'b0 || ackB !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_acks: got ack_a=%b ack_b=%b expected 0 0", ackA, ackB);
    end
    testCount++;
  endtask

  task automatic test_walk();
    int expX[3] = '{516, 520, 524};
    applyReset();
    reqA = 1; tgtAX = 12'sd600; tgtAY = 12'sd384;
    tick();
    if (ackA !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL walk_ack: got ack_a=%b expected 1", ackA);
    end
    testCount++;
    reqA = 0;
    tick();
    if (ackA !== 1'b0 || ackB !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL walk_ack_once: got ack_a=%b ack_b=%b expected 0 0", ackA, ackB);
    end
    testCount++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus_frame();
      if (x !== 12'(expX[i]) || y !== 12'(384) || moving !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL walk_step%0d: got x=%0d y=%0d moving=%b expected x=%0d y=384 moving=1",
                 i, x, y, moving, expX[i]);
      end
      testCount++;
      tick();
    end
  endtask

  task automatic test_arrive();
    applyReset();
    reqA = 1; tgtAX = 12'sd514; tgtAY = 12'sd384;
    tick();
    reqA = 0;
    tick();
    applyStimulus_frame();
    if (x !== 12'(514) || arrived !== 1'b1 || moving !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL arrive_frame: got x=%0d arrived=%b moving=%b expected x=514 arrived=1 moving=0",
               x, arrived, moving);
    end
    testCount++;
    tick();
    if (arrived !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL arrive_once: got arrived=%b expected 0", arrived);
    end
    testCount++;
  endtask

  task automatic test_round_robin();
    applyReset();
    reqA = 1; tgtAX = 12'sd600; tgtAY = 12'sd384;
    reqB = 1; tgtBX = 12'sd400; tgtBY = 12'sd384;
    tick();
    if (ackA !== 1'b1 || ackB !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rr_first_a: got ack_a=%b ack_b=%b expected 1 0", ackA, ackB);
    end
    testCount++;
    reqA = 0;
    tick();
    if (ackB !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rr_b_waits: got ack_b=%b expected 0", ackB);
    end
    testCount++;
    reqA = 1;
    applyStimulus_frame();
    tick();
    if (ackA !== 1'b0 || ackB !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL rr_then_b: got ack_a=%b ack_b=%b expected 0 1", ackA, ackB);
    end
    testCount++;
    reqB = 0;
    tick();
    applyStimulus_frame();
    tick();
    if (ackA !== 1'b1 || ackB !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rr_then_a: got ack_a=%b ack_b=%b expected 1 0", ackA, ackB);
    end
    testCount++;
    reqA = 0;
    tick();
  endtask

  task automatic test_clamp();
    int pathErrors = 0;
    int arrivals   = 0;
    int arrFrame   = -1;
    int ex, ey;
    applyReset();
    reqA = 1; tgtAX = 12'sd5; tgtAY = 12'sd2000;
    tick();
    reqA = 0;
    tick();
    for (int k = 1; k <= 130; k++) begin
      applyStimulus_frame();
      ex = (512 - 4 * k < X_LO) ? X_LO : 512 - 4 * k;
      ey = (384 + 4 * k > Y_HI) ? Y_HI : 384 + 4 * k;
      if (x !== 12'(ex) || y !== 12'(ey)) pathErrors++;
      if (arrived === 1'b1) begin
        arrivals++;
        arrFrame = k;
      end
      tick();
    end
    if (pathErrors != 0) begin
      failCount++;
      $display("[TB] FAIL clamp_path: got %0d off-path frames, final (%0d,%0d), expected 0 and (32,735)",
               pathErrors, x, y);
    end
    testCount++;
    if (arrivals != 1 || arrFrame != 120) begin
      failCount++;
      $display("[TB] FAIL clamp_arrived: got %0d pulses last at frame %0d expected 1 at frame 120",
               arrivals, arrFrame);
    end
    testCount++;
    if (moving !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL clamp_stopped: got moving=%b expected 0", moving);
    end
    testCount++;
  endtask

  task automatic test_pending_full();
    bit sawB = 0;
    applyReset();
    reqA = 1; tgtAX = 12'sd700; tgtAY = 12'sd400;
    tick();
    reqA = 0;
    reqB = 1; tgtBX = 12'sd300; tgtBY = 12'sd200;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (ackB === 1'b1) sawB = 1;
    end
    if (sawB) begin
      failCount++;
      $display("[TB] FAIL full_no_ack: got ack_b pulse while slot full expected none");
    end
    testCount++;
    applyStimulus_frame();
    if (ackB !== 1'b0 || x !== 12'(516) || y !== 12'(388)) begin
      failCount++;
      $display("[TB] FAIL full_drain: got ack_b=%b pos=(%0d,%0d) expected 0 (516,388)", ackB, x, y);
    end
    testCount++;
    tick();
    if (ackB !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL full_ack_b: got ack_b=%b expected 1", ackB);
    end
    testCount++;
    reqB = 0;
    tick();
  endtask

  task automatic test_reset_mid_move();
    applyReset();
    reqA = 1; tgtAX = 12'sd900; tgtAY = 12'sd384;
    tick();
    reqA = 0;
    tick();
    applyStimulus_frame();
    tick();
    reqB = 1; tgtBX = 12'sd100; tgtBY = 12'sd100;
    tick();
    reqB = 0;
    tick();
    reqA = 1; tgtAX = 12'sd200; tgtAY = 12'sd200;
    reset = 1; frameStart = 1;
    tick();
    if (x !== 12'(HOME_X) || y !== 12'(HOME_Y) || moving !== 1'b0 ||
        ackA !== 1'b0 || ackB !== 1'b0 || arrived !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midmove_reset: got (%0d,%0d) mv=%b ackA=%b ackB=%b arr=%b expected (512,384) 0 0 0 0",
               x, y, moving, ackA, ackB, arrived);
    end
    testCount++;
    reset = 0; frameStart = 0; reqA = 0;
    tick();
    applyStimulus_frame();
    if (x !== 12'(HOME_X) || y !== 12'(HOME_Y) || moving !== 1'b0 || arrived !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midmove_discard: got (%0d,%0d) mv=%b arr=%b expected (512,384) 0 0",
               x, y, moving, arrived);
    end
    testCount++;
    tick();
  endtask

  task automatic test_random();
    bit dropNextA = 0;
    bit dropNextB = 0;
    applyReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (dropNextA) begin
        reqA = 0; dropNextA = 0;
      end else if (reqA && mAckA) begin
        if ($urandom_range(1, 0) == 0) reqA = 0;
        else dropNextA = 1;
      end else if (!reqA && $urandom_range(3, 0) == 0) begin
        reqA = 1; tgtAX = pickTarget(mX); tgtAY = pickTarget(mY);
      end
      if (dropNextB) begin
        reqB = 0; dropNextB = 0;
      end else if (reqB && mAckB) begin
        if ($urandom_range(1, 0) == 0) reqB = 0;
        else dropNextB = 1;
      end else if (!reqB && $urandom_range(3, 0) == 0) begin
        reqB = 1; tgtBX = pickTarget(mX); tgtBY = pickTarget(mY);
      end
      frameStart = ($urandom_range(5, 0) == 0);
      reset      = ($urandom_range(499, 0) == 0);
      tick();
      testCount++;
      if (x !== 12'(mX) || y !== 12'(mY) || moving !== mMoving || arrived !== mArr ||
          ackA !== mAckA || ackB !== mAckB) begin
        failCount++;
        $display("[TB] FAIL random_cycle%0d: got x=%0d y=%0d mv=%b arr=%b ackA=%b ackB=%b expected x=%0d y=%0d mv=%b arr=%b ackA=%b ackB=%b",
                 cyc, x, y, moving, arrived, ackA, ackB, mX, mY, mMoving, mArr, mAckA, mAckB);
        break;
      end
    end
    reset = 0; reqA = 0; reqB = 0; frameStart = 0;
  endtask

  initial begin
    reset = 1; frameStart = 0; reqA = 0; reqB = 0;
    tgtAX = '0; tgtAY = '0; tgtBX = '0; tgtBY = '0;
    test_reset();
    test_walk();
    test_arrive();
    test_round_robin();
    test_clamp();
    test_pending_full();
    test_reset_mid_move();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
